signed_mul_seq: RTL and testbench

Multi-cycle signed 16x16 -> 32-bit multiplier sequencer for the TPU MAC path. It shares one 32-bit conditional-complement unit across three steps: operand A magnitude, operand B magnitude, and result sign fix-up. Between those steps it runs a radix-2 shift-add loop. Upstream and downstream connect through valid/ready handshakes.

---
 rtl/signed_mul_seq_pkg.sv | 17 +
 rtl/signed_mul_seq_cond_negate32.sv | 17 +
 rtl/signed_mul_seq.sv | 124 ++++++++++++
 tb/tb_signed_mul_seq.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/signed_mul_seq_pkg.sv
// Shared definitions for the signed sequential multiplier: sequencer states and
// default widths.
package signed_mul_seq_pkg;

   localparam int unsigned DEF_WIDTH  = 16;
   localparam int unsigned DEF_PROD_W = 2 * DEF_WIDTH;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ABS_A = 3'd1,
      ABS_B = 3'd2,
      MUL   = 3'd3,
      FIX   = 3'd4,
      DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/signed_mul_seq_cond_negate32.sv
// Conditional two's-complement negation: result = (data ^ {W{neg}}) + neg.
// Shared by the multiplier for both operand magnitudes and the result sign fix-up.
module cond_negate32
   import signed_mul_seq_pkg::*;
#(
   parameter int unsigned W = DEF_PROD_W
)(
   input  logic [W-1:0] data,
   input  logic         neg,
   output logic [W-1:0] result
);

   always_comb begin
      result = (data ^ {W{neg}}) + {{(W-1){1'b0}}, neg};
   end

endmodule

// File: rtl/signed_mul_seq.sv
// Multi-cycle signed WIDTH x WIDTH multiplier: sign/magnitude conversion through one
// shared negate unit, a radix-2 shift-add loop, then sign fix-up of the product.
module signed_mul_seq
   import signed_mul_seq_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int unsigned PROD_W = 2 * WIDTH;
   localparam int unsigned CNT_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t              state, state_nx;
   logic [WIDTH-1:0]    a_reg, b_reg, mag_a, mag_b;
   logic                sign;
   logic [PROD_W-1:0]   acc, product_reg;
   logic [CNT_W-1:0]    cnt;
   logic [PROD_W-1:0]   neg_data, neg_result;
   logic                neg_ctl;
   logic                accept;

   assign accept  = in_valid & in_ready;
   assign product = product_reg;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid) state_nx = ABS_A;
         ABS_A:   state_nx = ABS_B;
         ABS_B:   state_nx = MUL;
         MUL:     if (cnt == CNT_LAST) state_nx = FIX;
         FIX:     state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      busy      = (state != IDLE);
      out_valid = (state == DONE);
   end

   // One negate unit serves three steps; idle steps feed it zero.
   always_comb begin
      neg_data = '0;
      neg_ctl  = 1'b0;
      case (state)
         ABS_A: begin
            neg_data = {{WIDTH{a_reg[WIDTH-1]}}, a_reg};
            neg_ctl  = a_reg[WIDTH-1];
         end
         ABS_B: begin
            neg_data = {{WIDTH{b_reg[WIDTH-1]}}, b_reg};
            neg_ctl  = b_reg[WIDTH-1];
         end
         FIX: begin
            neg_data = acc;
            neg_ctl  = sign;
         end
         default: ;
      endcase
   end

   cond_negate32 #(.W(PROD_W)) u_negate (
      .data   (neg_data),
      .neg    (neg_ctl),
      .result (neg_result)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         a_reg       <= '0;
         b_reg       <= '0;
         sign        <= 1'b0;
         mag_a       <= '0;
         mag_b       <= '0;
         acc         <= '0;
         cnt         <= '0;
         product_reg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_reg <= a;
                  b_reg <= b;
                  sign  <= a[WIDTH-1] ^ b[WIDTH-1];
               end
            end
            // Low WIDTH bits suffice: the most negative operand maps to 2^(WIDTH-1) unsigned.
            ABS_A: mag_a <= neg_result[WIDTH-1:0];
            ABS_B: begin
               mag_b <= neg_result[WIDTH-1:0];
               acc   <= '0;
               cnt   <= '0;
            end
            MUL: begin
               if (mag_b[0]) acc <= acc + (PROD_W'(mag_a) << cnt);
               mag_b <= mag_b >> 1;
               cnt   <= cnt + 1'b1;
            end
            FIX: product_reg <= neg_result;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_signed_mul_seq.sv
// Directed self-checking bench for signed_mul_seq: reset, latency, sign cases,
// output back-pressure and abort by reset.
module tb_signed_mul_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] product;
   logic        busy;

   int errors = 0;
   int checks = 0;

   signed_mul_seq #(.WIDTH(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Called at a negedge with the block idle; operands are taken on the next posedge.
   task automatic accept_op(input logic [15:0] va, input logic [15:0] vb);
      a        = va;
      b        = vb;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Returns cycles from acceptance to out_valid (0 on timeout) and whether busy held.
   task automatic wait_done(output int lat, output bit busy_ok);
      lat     = 0;
      busy_ok = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (out_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (product !== 32'h0) begin errors++; $display("FAIL reset_product got=%h exp=00000000", product); end
   endtask

   task automatic test_basic();
      int lat;
      bit bok;
      accept_op(16'd3, 16'd5);
      wait_done(lat, bok);
      checks++; if (lat !== 20) begin errors++; $display("FAIL basic_latency got=%0d exp=20", lat); end
      checks++; if (bok !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", bok); end
      checks++; if (product !== 32'h0000000F) begin errors++; $display("FAIL basic_product got=%h exp=0000000f", product); end
      release_out();
   endtask

   task automatic test_signs();
      logic [15:0] va [5] = '{16'hFFF9, 16'h8000, 16'h8000, 16'h0000, 16'hFFFF};
      logic [15:0] vb [5] = '{16'h0006, 16'h8000, 16'h0001, 16'hFFFF, 16'hFFFF};
      logic [31:0] ve [5] = '{32'hFFFFFFD6, 32'h40000000, 32'hFFFF8000, 32'h00000000, 32'h00000001};
      int lat;
      bit bok;
      for (int i = 0; i < 5; i++) begin
         accept_op(va[i], vb[i]);
         wait_done(lat, bok);
         checks++; if (lat !== 20) begin errors++; $display("FAIL signs_latency[%0d] got=%0d exp=20", i, lat); end
         checks++; if (product !== ve[i]) begin errors++; $display("FAIL signs_product[%0d] a=%h b=%h got=%h exp=%h", i, va[i], vb[i], product, ve[i]); end
         release_out();
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      bit bok;
      bit stable_ok;
      accept_op(16'h0010, 16'hFFFD);
      wait_done(lat, bok);
      checks++; if (product !== 32'hFFFFFFD0) begin errors++; $display("FAIL stall_product got=%h exp=ffffffd0", product); end
      stable_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== 32'hFFFFFFD0) stable_ok = 1'b0;
      end
      checks++; if (stable_ok !== 1'b1) begin errors++; $display("FAIL stall_hold got=%b exp=1 (ov=%b ir=%b p=%h)", stable_ok, out_valid, in_ready, product); end
      release_out();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL handshake_out_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL handshake_in_ready got=%b exp=1", in_ready); end
      accept_op(16'h0100, 16'h0100);
      wait_done(lat, bok);
      checks++; if (lat !== 20) begin errors++; $display("FAIL b2b_latency got=%0d exp=20", lat); end
      checks++; if (product !== 32'h00010000) begin errors++; $display("FAIL b2b_product got=%h exp=00010000", product); end
      release_out();
      checks++; if (product !== 32'h00010000) begin errors++; $display("FAIL idle_product_hold got=%h exp=00010000", product); end
   endtask

   task automatic test_mid_reset();
      bit no_pulse;
      accept_op(16'h7FFF, 16'h7FFF);
      for (int i = 1; i < 8; i++) @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
      checks++; if (product !== 32'h0) begin errors++; $display("FAIL abort_product got=%h exp=00000000", product); end
      no_pulse = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || busy !== 1'b0) no_pulse = 1'b0;
      end
      checks++; if (no_pulse !== 1'b1) begin errors++; $display("FAIL abort_no_output got=%b exp=1", no_pulse); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_back_to_back();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
